// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch constants, IF state encoding.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP    = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } if_state_t;
endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register: valid bit plus instr/pc/pc4 payload.
// flush clears valid only (payload kept), hold freezes everything, load captures.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         flush,
  input  logic         hold,
  input  logic [W-1:0] d_instr,
  input  logic [W-1:0] d_pc,
  input  logic [W-1:0] d_pc4,
  output logic         q_valid,
  output logic [W-1:0] q_instr,
  output logic [W-1:0] q_pc,
  output logic [W-1:0] q_pc4
);

  // Priority flush > hold > load; payload survives a flush so consumers key off valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_instr <= W'(NOP);
      q_pc    <= '0;
      q_pc4   <= '0;
    end else if (flush) begin
      q_valid <= 1'b0;
    end else if (!hold && load) begin
      q_valid <= 1'b1;
      q_instr <= d_instr;
      q_pc    <= d_pc;
      q_pc4   <= d_pc4;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, BOOT/RUN/FAULT control, IF/ID capture.
// Redirect > stall > out-of-range > advance; misaligned redirect is terminal.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        fault
);

  if_state_t   state, state_nxt;
  logic [31:0] pc, pc_nxt, pc4;
  logic        oor, misaligned;
  logic        ld, fl, hd;

  assign pc4        = pc + PC_INC;
  assign oor        = (pc >= 32'(IM_BYTES));
  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign imem_addr  = pc;
  assign fault      = (state == FAULT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // Next state: BOOT always moves on; only a misaligned redirect leaves RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (redirect && misaligned) state_nxt = FAULT;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = BOOT;
    endcase
  end

  // Datapath control: next pc and IF/ID load/flush/hold.
  always_comb begin
    pc_nxt = pc;
    ld     = 1'b0;
    fl     = 1'b0;
    hd     = 1'b1;
    case (state)
      RUN: begin
        if (redirect) begin
          fl = 1'b1;
          hd = 1'b0;
          if (!misaligned) pc_nxt = redirect_pc;
        end else if (stall) begin
          hd = 1'b1;
        end else if (oor) begin
          fl = 1'b1;
          hd = 1'b0;
        end else begin
          ld     = 1'b1;
          hd     = 1'b0;
          pc_nxt = pc4;
        end
      end
      FAULT:   fl = 1'b1;
      default: hd = 1'b1;
    endcase
  end

  // Program counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_nxt;
  end

  if_id_reg #(.W(XLEN)) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ld),
    .flush   (fl),
    .hold    (hd),
    .d_instr (imem_data),
    .d_pc    (pc),
    .d_pc4   (pc4),
    .q_valid (if_id_valid),
    .q_instr (if_id_instr),
    .q_pc    (if_id_pc),
    .q_pc4   (if_id_pc4)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a combinational instruction memory model.
module tb_if_stage;
  logic        clk, rst_n;
  logic [31:0] imem_addr, imem_data;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid, fault;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [128];

  if_stage #(.RESET_PC(32'h0), .IM_BYTES(128)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .fault       (fault)
  );

  assign imem_data = mem[imem_addr[8:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i);
    return 32'h2008_0001 + 32'(i) * 32'h0001_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] p, input logic [31:0] addr);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, v});
    chk({tag, ".instr"}, if_id_instr, ins);
    chk({tag, ".pc"},    if_id_pc, p);
    chk({tag, ".pc4"},   if_id_pc4, p + 32'd4);
    chk({tag, ".addr"},  imem_addr, addr);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = word(i);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1;
    chk("rst.valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst.instr", if_id_instr, 32'd0);
    chk("rst.pc",    if_id_pc, 32'd0);
    chk("rst.pc4",   if_id_pc4, 32'd0);
    chk("rst.fault", {31'b0, fault}, 32'd0);
    chk("rst.addr",  imem_addr, 32'd0);
    #1 rst_n = 1'b1;

    // BOOT cycle: a redirect here must be ignored
    redirect = 1'b1; redirect_pc = 32'h60;
    step();
    redirect = 1'b0;
    chk("boot.valid", {31'b0, if_id_valid}, 32'd0);
    chk("boot.addr",  imem_addr, 32'd0);
    step();
    chk_if("fetch0", 1'b1, 32'h2008_0001, 32'h0, 32'h4);
    step();
    chk_if("fetch1", 1'b1, 32'h2009_0002, 32'h4, 32'h8);

    // stall three cycles at pc = 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_if($sformatf("stall%0d", i), 1'b1, 32'h2009_0002, 32'h4, 32'h8);
    end
    stall = 1'b0;
    step();
    chk_if("unstall", 1'b1, 32'h200A_0003, 32'h8, 32'hC);

    // redirect wins over stall
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    stall = 1'b0; redirect = 1'b0;
    chk("redir.addr",  imem_addr, 32'h40);
    chk("redir.valid", {31'b0, if_id_valid}, 32'd0);
    step();
    chk_if("redir.tgt", 1'b1, 32'h2018_0011, 32'h40, 32'h44);

    // run sequentially to the end of memory
    for (int a = 32'h44; a < 32'h80; a += 4) begin
      step();
      chk($sformatf("seq%0h.pc", a), if_id_pc, 32'(a));
      chk($sformatf("seq%0h.instr", a), if_id_instr, word(a / 4));
    end
    chk("end.addr", imem_addr, 32'h80);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_if($sformatf("oor%0d", i), 1'b0, word(31), 32'h7C, 32'h80);
      chk($sformatf("oor%0d.fault", i), {31'b0, fault}, 32'd0);
    end
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    chk("oorredir.addr",  imem_addr, 32'h10);
    chk("oorredir.valid", {31'b0, if_id_valid}, 32'd0);
    step();
    chk_if("oorredir.tgt", 1'b1, word(4), 32'h10, 32'h14);
    chk("oorredir.fault", {31'b0, fault}, 32'd0);

    // misaligned redirect: sticky fault, pc frozen
    redirect = 1'b1; redirect_pc = 32'h22;
    step();
    redirect_pc = 32'h30;
    chk("fault.set",   {31'b0, fault}, 32'd1);
    chk("fault.valid", {31'b0, if_id_valid}, 32'd0);
    chk("fault.addr",  imem_addr, 32'h14);
    step();
    redirect = 1'b0;
    chk("fault.keep",  {31'b0, fault}, 32'd1);
    chk("fault.addr2", imem_addr, 32'h14);
    step();
    chk("fault.keep2", {31'b0, fault}, 32'd1);

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst.fault", {31'b0, fault}, 32'd0);
    chk("arst.valid", {31'b0, if_id_valid}, 32'd0);
    chk("arst.addr",  imem_addr, 32'd0);
    chk("arst.instr", if_id_instr, 32'd0);
    #1 rst_n = 1'b1;
    step();
    chk("reboot.valid", {31'b0, if_id_valid}, 32'd0);
    step();
    chk_if("reboot.f0", 1'b1, 32'h2008_0001, 32'h0, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
